// File: rtl/spi_xip_pkg.sv
// Shared constants and types for the SPI XIP read sequencer.
// Register map, CTRL fields, FSM state codes and bus owner enum.
package spi_xip_pkg;

  localparam logic [4:0] REG_RX0  = 5'h00;
  localparam logic [4:0] REG_TX1  = 5'h04;
  localparam logic [4:0] REG_CTRL = 5'h10;
  localparam logic [4:0] REG_DIV  = 5'h14;
  localparam logic [4:0] REG_SS   = 5'h18;

  localparam int CTRL_GO_BSY = 8;
  localparam int CTRL_LEN_W  = 7;

  localparam logic [CTRL_LEN_W-1:0] CTRL_LEN_64 = 7'd64;

  localparam logic [31:0] CTRL_XIP_GO =
    (32'd1 << CTRL_GO_BSY) | {25'd0, CTRL_LEN_64};

  typedef logic [3:0] xip_state_t;

  localparam xip_state_t ST_IDLE   = 4'd0;
  localparam xip_state_t ST_WR_TX1 = 4'd1;
  localparam xip_state_t ST_WR_DIV = 4'd2;
  localparam xip_state_t ST_WR_SS  = 4'd3;
  localparam xip_state_t ST_WR_CTL = 4'd4;
  localparam xip_state_t ST_POLL   = 4'd5;
  localparam xip_state_t ST_RD_RX0 = 4'd6;
  localparam xip_state_t ST_CLR_SS = 4'd7;
  localparam xip_state_t ST_RESP   = 4'd8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_SW   = 2'd1,
    OWN_XIP  = 2'd2
  } owner_t;

  function automatic logic [31:0] bswap32(
    input logic [31:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic is_cfg_reg(
    input logic [4:0] a
  );
    return (a == REG_TX1) || (a == REG_CTRL) ||
           (a == REG_DIV) || (a == REG_SS);
  endfunction

endpackage

// File: rtl/spi_xip_wb_arb.sv
// Wishbone arbiter between the software port and the XIP engine.
// Owner register with round-robin on contest, plus m_*/sw_* muxing.
module spi_xip_wb_arb
  import spi_xip_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  sw_adr_i,
  input  logic [31:0] sw_dat_i,
  input  logic [3:0]  sw_sel_i,
  input  logic        sw_we_i,
  input  logic        sw_stb_i,
  input  logic        sw_cyc_i,
  output logic [31:0] sw_dat_o,
  output logic        sw_ack_o,
  output logic        sw_err_o,
  input  logic        x_req,
  input  logic        x_release,
  input  logic [4:0]  x_adr,
  input  logic [31:0] x_dat,
  input  logic        x_we,
  input  logic        x_cyc,
  output logic        x_grant,
  output logic [4:0]  m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i
);

  owner_t owner_q;
  logic   last_xip_q;
  logic   idle;
  logic   sw_win;

  assign idle    = (owner_q == OWN_NONE);
  assign sw_win  = idle && sw_cyc_i &&
                   (!x_req || last_xip_q);
  assign x_grant = idle && x_req && !sw_win;

  // Owner register; last_xip starts set so SW wins the first contest
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q    <= OWN_NONE;
      last_xip_q <= 1'b1;
    end else begin
      unique case (owner_q)
        OWN_NONE: begin
          if (sw_win) begin
            owner_q    <= OWN_SW;
            last_xip_q <= 1'b0;
          end else if (x_grant) begin
            owner_q    <= OWN_XIP;
            last_xip_q <= 1'b1;
          end
        end
        OWN_SW: begin
          if (!sw_cyc_i) owner_q <= OWN_NONE;
        end
        OWN_XIP: begin
          if (x_release) owner_q <= OWN_NONE;
        end
        default: owner_q <= OWN_NONE;
      endcase
    end
  end

  // Route the master port to whoever owns the bus
  always_comb begin
    m_adr_o  = '0;
    m_dat_o  = '0;
    m_sel_o  = '0;
    m_we_o   = 1'b0;
    m_stb_o  = 1'b0;
    m_cyc_o  = 1'b0;
    sw_dat_o = '0;
    sw_ack_o = 1'b0;
    sw_err_o = 1'b0;
    unique case (1'b1)
      (owner_q == OWN_SW): begin
        m_adr_o  = sw_adr_i;
        m_dat_o  = sw_dat_i;
        m_sel_o  = sw_sel_i;
        m_we_o   = sw_we_i;
        m_stb_o  = sw_stb_i;
        m_cyc_o  = sw_cyc_i;
        sw_dat_o = m_dat_i;
        sw_ack_o = m_ack_i;
        sw_err_o = m_err_i;
      end
      (owner_q == OWN_XIP): begin
        m_adr_o = x_adr;
        m_dat_o = x_dat;
        m_sel_o = x_cyc ? 4'hF : 4'h0;
        m_we_o  = x_we;
        m_stb_o = x_cyc;
        m_cyc_o = x_cyc;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/spi_xip_ctrl.sv
// XIP read sequencer in front of spi_top, sharing its WB slave port.
// Optional one-entry read buffer enabled by SPI_XIP_CACHE_EN.
module spi_xip_ctrl
  import spi_xip_pkg::*;
#(
  parameter logic [31:0] SPI_DIVIDER  = 32'h1,
  parameter logic [7:0]  SS_MASK      = 8'h01,
  parameter logic [7:0]  FLASH_CMD    = 8'h03,
  parameter int          POLL_TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        xip_req_valid,
  output logic        xip_req_ready,
  input  logic [31:0] xip_req_addr,
  output logic        xip_rsp_valid,
  output logic [31:0] xip_rsp_data,
  output logic        xip_rsp_err,
  input  logic [4:0]  sw_adr_i,
  input  logic [31:0] sw_dat_i,
  input  logic [3:0]  sw_sel_i,
  input  logic        sw_we_i,
  input  logic        sw_stb_i,
  input  logic        sw_cyc_i,
  output logic [31:0] sw_dat_o,
  output logic        sw_ack_o,
  output logic        sw_err_o,
  output logic [4:0]  m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i
);

  localparam int PCW = $clog2(POLL_TIMEOUT + 1);

  xip_state_t  state_q;
  xip_state_t  state_d;
  logic        gap_q;
  logic        err_q;
  logic [PCW-1:0] poll_q;
  logic [21:0] addr_q;
  logic [31:0] rx_q;
  logic [31:0] rsp_q;

  logic        acc_st;
  logic        x_cyc;
  logic        x_we;
  logic [4:0]  x_adr;
  logic [31:0] x_dat;
  logic        x_req;
  logic        x_grant;
  logic        acc_done;
  logic        hs;
  logic        hit;
  logic [31:0] c_data;
  logic        busy;
  logic        poll_last;
  logic        poll_to;
  logic        fill;
  logic        unused_addr;

  assign unused_addr =
    ^{xip_req_addr[31:24], xip_req_addr[1:0]};

  assign acc_st   = (state_q != ST_IDLE) &&
                    (state_q != ST_RESP);
  assign x_cyc    = acc_st && !gap_q;
  assign acc_done = x_cyc && (m_ack_i || m_err_i);
  assign busy     = m_dat_i[CTRL_GO_BSY];

  assign x_req = (state_q == ST_IDLE) &&
                 xip_req_valid && !hit;
  assign xip_req_ready = (state_q == ST_IDLE) &&
                         (hit || x_grant);
  assign hs = xip_req_valid && xip_req_ready;

  assign poll_last = (poll_q == PCW'(POLL_TIMEOUT - 1));
  assign poll_to   = (state_q == ST_POLL) && acc_done &&
                     !m_err_i && busy && poll_last;
  assign fill      = (state_q == ST_CLR_SS) && acc_done &&
                     !err_q && !m_err_i;

  assign xip_rsp_valid = (state_q == ST_RESP);
  assign xip_rsp_err   = xip_rsp_valid && err_q;
  assign xip_rsp_data  = xip_rsp_valid ? rsp_q : '0;

`ifdef SPI_XIP_CACHE_EN
  logic        c_valid_q;
  logic [21:0] c_tag_q;
  logic [31:0] c_data_q;
  logic        sw_cfg_wr;

  assign sw_cfg_wr = sw_cyc_i && sw_stb_i && sw_we_i &&
                     is_cfg_reg(sw_adr_i);
  assign hit    = c_valid_q &&
                  (c_tag_q == xip_req_addr[23:2]);
  assign c_data = c_data_q;

  // Read buffer: config writes invalidate, clean reads refill
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_valid_q <= 1'b0;
      c_tag_q   <= '0;
      c_data_q  <= '0;
    end else if (sw_cfg_wr) begin
      c_valid_q <= 1'b0;
    end else if (fill) begin
      c_valid_q <= 1'b1;
      c_tag_q   <= addr_q;
      c_data_q  <= rx_q;
    end
  end
`else
  logic unused_fill;

  assign unused_fill = fill;
  assign hit    = 1'b0;
  assign c_data = '0;
`endif

  // Bus fields for the access belonging to each state
  always_comb begin
    x_adr = '0;
    x_dat = '0;
    x_we  = 1'b0;
    unique case (state_q)
      ST_WR_TX1: begin
        x_adr = REG_TX1;
        x_dat = {FLASH_CMD, addr_q, 2'b00};
        x_we  = 1'b1;
      end
      ST_WR_DIV: begin
        x_adr = REG_DIV;
        x_dat = SPI_DIVIDER;
        x_we  = 1'b1;
      end
      ST_WR_SS: begin
        x_adr = REG_SS;
        x_dat = {24'd0, SS_MASK};
        x_we  = 1'b1;
      end
      ST_WR_CTL: begin
        x_adr = REG_CTRL;
        x_dat = CTRL_XIP_GO;
        x_we  = 1'b1;
      end
      ST_POLL:   x_adr = REG_CTRL;
      ST_RD_RX0: x_adr = REG_RX0;
      ST_CLR_SS: begin
        x_adr = REG_SS;
        x_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer next state; any bus error diverts to SS release
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hs) state_d = hit ? ST_RESP : ST_WR_TX1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: begin
        if (acc_done) begin
          if (m_err_i) begin
            state_d = (state_q == ST_CLR_SS) ?
                      ST_RESP : ST_CLR_SS;
          end else begin
            unique case (state_q)
              ST_WR_TX1: state_d = ST_WR_DIV;
              ST_WR_DIV: state_d = ST_WR_SS;
              ST_WR_SS:  state_d = ST_WR_CTL;
              ST_WR_CTL: state_d = ST_POLL;
              ST_POLL: begin
                if (!busy)
                  state_d = ST_RD_RX0;
                else if (poll_last)
                  state_d = ST_CLR_SS;
              end
              ST_RD_RX0: state_d = ST_CLR_SS;
              ST_CLR_SS: state_d = ST_RESP;
              default:   state_d = ST_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // Sequencer registers: state, idle gap, error, poll count, data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gap_q   <= 1'b0;
      err_q   <= 1'b0;
      poll_q  <= '0;
      addr_q  <= '0;
      rx_q    <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= acc_done;
      if (hs) begin
        addr_q <= xip_req_addr[23:2];
        err_q  <= 1'b0;
        poll_q <= '0;
      end
      if ((acc_done && m_err_i) || poll_to)
        err_q <= 1'b1;
      if ((state_q == ST_POLL) && acc_done &&
          !m_err_i && busy)
        poll_q <= poll_q + 1'b1;
      if ((state_q == ST_RD_RX0) && acc_done && !m_err_i)
        rx_q <= m_dat_i;
      if (hs && hit)
        rsp_q <= bswap32(c_data);
      if ((state_q == ST_CLR_SS) && acc_done)
        rsp_q <= (err_q || m_err_i) ? '0 : bswap32(rx_q);
    end
  end

  spi_xip_wb_arb u_arb (
    .clock     (clock),
    .reset     (reset),
    .sw_adr_i  (sw_adr_i),
    .sw_dat_i  (sw_dat_i),
    .sw_sel_i  (sw_sel_i),
    .sw_we_i   (sw_we_i),
    .sw_stb_i  (sw_stb_i),
    .sw_cyc_i  (sw_cyc_i),
    .sw_dat_o  (sw_dat_o),
    .sw_ack_o  (sw_ack_o),
    .sw_err_o  (sw_err_o),
    .x_req     (x_req),
    .x_release (state_q == ST_RESP),
    .x_adr     (x_adr),
    .x_dat     (x_dat),
    .x_we      (x_we),
    .x_cyc     (x_cyc),
    .x_grant   (x_grant),
    .m_adr_o   (m_adr_o),
    .m_dat_o   (m_dat_o),
    .m_sel_o   (m_sel_o),
    .m_we_o    (m_we_o),
    .m_stb_o   (m_stb_o),
    .m_cyc_o   (m_cyc_o),
    .m_dat_i   (m_dat_i),
    .m_ack_i   (m_ack_i),
    .m_err_i   (m_err_i)
  );

endmodule

// File: tb/tb_spi_xip_ctrl.sv
// Bench for spi_xip_ctrl with a behavioural spi_top slave.
// Expected accesses/responses are queued and checked as they occur.
module tb_spi_xip_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        xip_req_valid = 1'b0;
  logic        xip_req_ready;
  logic [31:0] xip_req_addr = '0;
  logic        xip_rsp_valid;
  logic [31:0] xip_rsp_data;
  logic        xip_rsp_err;
  logic [4:0]  sw_adr_i = '0;
  logic [31:0] sw_dat_i = '0;
  logic [3:0]  sw_sel_i = '0;
  logic        sw_we_i = 1'b0;
  logic        sw_stb_i = 1'b0;
  logic        sw_cyc_i = 1'b0;
  logic [31:0] sw_dat_o;
  logic        sw_ack_o;
  logic        sw_err_o;
  logic [4:0]  m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic        m_we_o;
  logic        m_stb_o;
  logic        m_cyc_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;
  logic        m_err_i;

  always #5 clock = ~clock;

  spi_xip_ctrl #(.POLL_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .xip_req_valid(xip_req_valid),
    .xip_req_ready(xip_req_ready),
    .xip_req_addr(xip_req_addr),
    .xip_rsp_valid(xip_rsp_valid),
    .xip_rsp_data(xip_rsp_data),
    .xip_rsp_err(xip_rsp_err),
    .sw_adr_i(sw_adr_i), .sw_dat_i(sw_dat_i),
    .sw_sel_i(sw_sel_i), .sw_we_i(sw_we_i),
    .sw_stb_i(sw_stb_i), .sw_cyc_i(sw_cyc_i),
    .sw_dat_o(sw_dat_o), .sw_ack_o(sw_ack_o),
    .sw_err_o(sw_err_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_sel_o(m_sel_o), .m_we_o(m_we_o),
    .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .m_err_i(m_err_i)
  );

  // slave model configuration (written only by the stimulus)
  logic [31:0] rx_cfg = '0;
  int          busy_cfg = 0;
  logic        stuck_cfg = 1'b0;
  logic [4:0]  err_adr = '0;
  int          err_id = 0;

  int err_done = 0;
  int busy_left;

  // spi_top stand-in: 1-cycle ack, GO_BSY busy for busy_cfg polls
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ack_i   <= 1'b0;
      m_err_i   <= 1'b0;
      m_dat_i   <= '0;
      busy_left <= 0;
    end else begin
      m_ack_i <= 1'b0;
      m_err_i <= 1'b0;
      if (m_cyc_o && m_stb_o && !m_ack_i && !m_err_i) begin
        if (err_id != err_done && m_adr_o == err_adr) begin
          m_err_i  <= 1'b1;
          err_done <= err_id;
        end else begin
          m_ack_i <= 1'b1;
          if (m_we_o && m_adr_o == 5'h10)
            busy_left <= busy_cfg;
          if (!m_we_o) begin
            if (m_adr_o == 5'h00) begin
              m_dat_i <= rx_cfg;
            end else if (m_adr_o == 5'h10) begin
              m_dat_i <= (stuck_cfg || busy_left > 0) ?
                         32'h100 : 32'h0;
              if (busy_left > 0) busy_left <= busy_left - 1;
            end else begin
              m_dat_i <= '0;
            end
          end
        end
      end
    end
  end

  typedef struct {
    logic [4:0]  adr;
    logic        we;
    logic [31:0] dat;
  } acc_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rx;
    int          busy;
    logic [31:0] tx1;
    logic [31:0] data;
  } vec_t;

  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  vec_t tbl[4];

  int checks = 0;
  int passed = 0;
  int cyc_n = 0;
  int cyc_seen = 0;
  int hs_cyc = 0;
  int rsp_cyc = 0;
  logic mon_en = 1'b0;
  logic last_done = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  task automatic fail(input string nm);
    checks++;
    $display("FAIL %s got=event exp=none", nm);
  endtask

  task automatic tick();
    logic done;
    acc_t e;
    rsp_t r;
    @(negedge clock);
    cyc_n++;
    if (m_cyc_o) cyc_seen++;
    done = m_cyc_o && m_stb_o && (m_ack_i || m_err_i);
    if (mon_en) begin
      if (last_done) chk("gap", 32'(m_cyc_o), 32'd0);
      if (done) begin
        if (exp_acc.size() == 0) begin
          fail("acc_extra");
        end else begin
          e = exp_acc.pop_front();
          chk("acc_adr", 32'(m_adr_o), 32'(e.adr));
          chk("acc_we", 32'(m_we_o), 32'(e.we));
          chk("acc_sel", 32'(m_sel_o), 32'hF);
          if (e.we) chk("acc_dat", m_dat_o, e.dat);
        end
      end
      last_done = done;
    end else begin
      last_done = 1'b0;
    end
    if (xip_rsp_valid) begin
      rsp_cyc = cyc_n;
      if (exp_rsp.size() == 0) begin
        fail("rsp_extra");
      end else begin
        r = exp_rsp.pop_front();
        chk("rsp_data", xip_rsp_data, r.data);
        chk("rsp_err", 32'(xip_rsp_err), 32'(r.err));
      end
    end
  endtask

  task automatic push_acc(input logic [4:0] a,
                          input logic we,
                          input logic [31:0] d);
    acc_t e;
    e.adr = a; e.we = we; e.dat = d;
    exp_acc.push_back(e);
  endtask

  task automatic push_rsp(input logic [31:0] d,
                          input logic err);
    rsp_t r;
    r.data = d; r.err = err;
    exp_rsp.push_back(r);
  endtask

  // ss_err: SS write errors; tmo: GO_BSY never clears
  task automatic push_seq(input logic [31:0] tx1,
                          input int busy,
                          input logic ss_err,
                          input logic tmo);
    push_acc(5'h04, 1'b1, tx1);
    push_acc(5'h14, 1'b1, 32'h1);
    push_acc(5'h18, 1'b1, 32'h1);
    if (!ss_err) begin
      push_acc(5'h10, 1'b1, 32'h140);
      if (tmo) begin
        repeat (8) push_acc(5'h10, 1'b0, 32'h0);
      end else begin
        repeat (busy + 1) push_acc(5'h10, 1'b0, 32'h0);
        push_acc(5'h00, 1'b0, 32'h0);
      end
    end
    push_acc(5'h18, 1'b1, 32'h0);
  endtask

  task automatic do_read(input logic [31:0] a);
    logic ok;
    ok = 1'b0;
    xip_req_addr = a;
    xip_req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (xip_req_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail("req_timeout");
    tick();
    hs_cyc = cyc_n;
    xip_req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 3000; i++) begin
      if (exp_rsp.size() == 0) break;
      tick();
    end
    if (exp_rsp.size() != 0) begin
      fail("rsp_timeout");
      exp_rsp.delete();
    end
    chk("acc_left", 32'(exp_acc.size()), 32'd0);
    exp_acc.delete();
  endtask

  task automatic sw_access(input logic [4:0] a,
                           input logic we,
                           input logic [31:0] d,
                           output logic [31:0] rd);
    logic ok;
    ok = 1'b0;
    mon_en = 1'b0;
    sw_adr_i = a; sw_we_i = we; sw_dat_i = d;
    sw_sel_i = 4'hF; sw_cyc_i = 1'b1; sw_stb_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (sw_ack_o || sw_err_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk("sw_ack", 32'(ok), 32'd1);
    rd = sw_dat_o;
    sw_cyc_i = 1'b0; sw_stb_i = 1'b0; sw_we_i = 1'b0;
    tick();
    mon_en = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    int seen0;

    tbl[0] = '{32'h3000_0104, 32'h1122_3344, 0,
               32'h0300_0104, 32'h4433_2211};
    tbl[1] = '{32'h3000_0010, 32'hA1B2_C3D4, 5,
               32'h0300_0010, 32'hD4C3_B2A1};
    tbl[2] = '{32'h00FF_FFFC, 32'hDEAD_BEEF, 0,
               32'h03FF_FFFC, 32'hEFBE_ADDE};
    tbl[3] = '{32'hFF80_0003, 32'h0000_0001, 2,
               32'h0380_0000, 32'h0100_0000};

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_cyc", 32'(m_cyc_o), 32'd0);
    chk("rst_stb", 32'(m_stb_o), 32'd0);
    chk("rst_adr", 32'(m_adr_o), 32'd0);
    chk("rst_mdat", m_dat_o, 32'd0);
    chk("rst_rsp_v", 32'(xip_rsp_valid), 32'd0);
    chk("rst_rsp_d", xip_rsp_data, 32'd0);
    chk("rst_sw_ack", 32'(sw_ack_o), 32'd0);
    chk("rst_ready", 32'(xip_req_ready), 32'd0);

    // first contest after reset: SW wins, XIP follows
    rx_cfg = 32'h1122_3344;
    sw_adr_i = 5'h00; sw_we_i = 1'b0; sw_sel_i = 4'hF;
    sw_cyc_i = 1'b1; sw_stb_i = 1'b1;
    xip_req_addr = tbl[0].addr;
    xip_req_valid = 1'b1;
    #1 chk("rr_first_ready", 32'(xip_req_ready), 32'd0);
    rd = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sw_ack_o) begin
        rd = sw_dat_o;
        break;
      end
    end
    chk("rr_sw_data", rd, 32'h1122_3344);
    chk("rr_sw_ready", 32'(xip_req_ready), 32'd0);
    sw_cyc_i = 1'b0; sw_stb_i = 1'b0;
    #1 chk("rr_drop_ready", 32'(xip_req_ready), 32'd0);
    tick();
    #1 chk("rr_next_ready", 32'(xip_req_ready), 32'd1);
    mon_en = 1'b1;
    push_seq(tbl[0].tx1, 0, 1'b0, 1'b0);
    push_rsp(tbl[0].data, 1'b0);
    do_read(tbl[0].addr);
    wait_rsp();

    for (int v = 0; v < 4; v++) begin
      rx_cfg = tbl[v].rx;
      busy_cfg = tbl[v].busy;
      push_seq(tbl[v].tx1, tbl[v].busy, 1'b0, 1'b0);
      push_rsp(tbl[v].data, 1'b0);
      do_read(tbl[v].addr);
      wait_rsp();
    end
    busy_cfg = 0;

    // bus error on the SS write, then a clean read
    err_adr = 5'h18;
    err_id = err_id + 1;
    push_seq(32'h0300_0104, 0, 1'b1, 1'b0);
    push_rsp(32'h0, 1'b1);
    do_read(32'h3000_0104);
    wait_rsp();
    rx_cfg = 32'h1122_3344;
    push_seq(32'h0300_0104, 0, 1'b0, 1'b0);
    push_rsp(32'h4433_2211, 1'b0);
    do_read(32'h3000_0104);
    wait_rsp();

    // GO_BSY stuck: poll limit of 8
    stuck_cfg = 1'b1;
    push_seq(32'h0300_0200, 0, 1'b0, 1'b1);
    push_rsp(32'h0, 1'b1);
    do_read(32'h3000_0200);
    wait_rsp();
    stuck_cfg = 1'b0;

    // reset in the middle of a read
    mon_en = 1'b0;
    busy_cfg = 3;
    do_read(32'h3000_0300);
    repeat (3) tick();
    reset = 1'b1;
    #1 chk("midrst_cyc", 32'(m_cyc_o), 32'd0);
    chk("midrst_rsp", 32'(xip_rsp_valid), 32'd0);
    tick();
    reset = 1'b0;
    busy_cfg = 0;
    tick();
    mon_en = 1'b1;

    // repeated read of one address, then SW SS write
    rx_cfg = 32'h0A0B_0C0D;
    busy_cfg = 1;
    push_seq(32'h0300_0010, 1, 1'b0, 1'b0);
    push_rsp(32'h0D0C_0B0A, 1'b0);
    do_read(32'h3000_0010);
    wait_rsp();
    rx_cfg = 32'h5566_7788;
`ifdef SPI_XIP_CACHE_EN
    push_rsp(32'h0D0C_0B0A, 1'b0);
    seen0 = cyc_seen;
    do_read(32'h3000_0010);
    wait_rsp();
    chk("hit_latency", 32'(rsp_cyc), 32'(hs_cyc));
    chk("hit_no_cyc", 32'(cyc_seen), 32'(seen0));
`else
    seen0 = 0;
    push_seq(32'h0300_0010, 1, 1'b0, 1'b0);
    push_rsp(32'h8877_6655, 1'b0);
    do_read(32'h3000_0010);
    wait_rsp();
`endif
    sw_access(5'h18, 1'b1, 32'h0, rd);
    push_seq(32'h0300_0010, 1, 1'b0, 1'b0);
    push_rsp(32'h8877_6655, 1'b0);
    do_read(32'h3000_0010);
    wait_rsp();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
